// File: rtl/spi_pkg.sv
// Shared types and constants for the SPI frame controller and its delay counter.
package spi_pkg;

  localparam int CHAR_LEN_MAX_DEF = 16;
  localparam int DLY_W            = 4;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_SETUP  = 3'd1,
    ST_TXWAIT = 3'd2,
    ST_RUN    = 3'd3,
    ST_HOLD   = 3'd4,
    ST_GAP    = 3'd5
  } state_t;

  // A delay of N cycles is spent as N-1 counted cycles plus the exit cycle.
  // 0 and 1 therefore both mean "leave on the next cycle".
  function automatic logic [DLY_W-1:0] dly_load(input logic [DLY_W-1:0] cycles);
    return (cycles == '0) ? '0 : cycles - 4'd1;
  endfunction

endpackage

// File: rtl/spi_delay_cnt.sv
// Loadable down-counter with zero flag, shared by the SETUP, HOLD and GAP phases.
module spi_delay_cnt
  import spi_pkg::*;
(
  input  logic             S_SYSCLK,
  input  logic             S_RESET,
  input  logic             load,
  input  logic [DLY_W-1:0] load_val,
  input  logic             dec,
  output logic             zero
);

  logic [DLY_W-1:0] count;

  always_ff @(posedge S_SYSCLK) begin
    if (S_RESET) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (dec && (count != '0)) begin
      count <= count - 4'd1;
    end
  end

  assign zero = (count == '0);

endmodule

// File: rtl/spi_frame_ctrl.sv
// Frame sequencer in front of the single-character SPI engine: CS timing, TX/RX streaming.
// Define SPI_CHAR_GAP_EN to add the S_CHAR_GAP input and an inter-character GAP state.
module spi_frame_ctrl
  import spi_pkg::*;
#(
  parameter int  CHAR_LEN_MAX = CHAR_LEN_MAX_DEF,
  parameter int  CS_W         = 2,
  parameter int  NCHAR_W      = 8,
  localparam int NUM_CS       = 2**CS_W
) (
  input  logic                    S_SYSCLK,
  input  logic                    S_RESET,
  input  logic                    S_ENABLE,
  input  logic                    S_CMD_VALID,
  output logic                    S_CMD_READY,
  input  logic [CS_W-1:0]         S_CMD_CS,
  input  logic [NCHAR_W-1:0]      S_CMD_NCHAR,
  input  logic [DLY_W-1:0]        S_CS_SETUP,
  input  logic [DLY_W-1:0]        S_CS_HOLD,
  input  logic                    S_TX_VALID,
  output logic                    S_TX_READY,
  input  logic [CHAR_LEN_MAX-1:0] S_TX_DATA,
  output logic                    S_RX_VALID,
  output logic [CHAR_LEN_MAX-1:0] S_RX_DATA,
  output logic                    S_BUSY,
  output logic                    S_FRAME_DONE,
  output logic                    S_FRAME_ABORT,
  output logic [NUM_CS-1:0]       S_SPI_CS_N,
  output logic                    S_CHAR_GO,
  input  logic                    S_CHAR_DONE,
  output logic [CHAR_LEN_MAX-1:0] S_WCHAR,
`ifdef SPI_CHAR_GAP_EN
  input  logic [DLY_W-1:0]        S_CHAR_GAP,
`endif
  input  logic [CHAR_LEN_MAX-1:0] S_RCHAR
);

  state_t                    state, state_d;
  logic [NCHAR_W-1:0]        remaining, remaining_d;
  logic [DLY_W-1:0]          hold_q, hold_d;

  logic                      cmd_ready_d, tx_ready_d, rx_valid_d, busy_d;
  logic                      frame_done_d, frame_abort_d, char_go_d;
  logic [NUM_CS-1:0]         cs_n_d;
  logic [CHAR_LEN_MAX-1:0]   rx_data_d, wchar_d;

  logic                      cnt_load, cnt_dec, cnt_zero;
  logic [DLY_W-1:0]          cnt_val;

  spi_delay_cnt u_delay (
    .S_SYSCLK (S_SYSCLK),
    .S_RESET  (S_RESET),
    .load     (cnt_load),
    .load_val (cnt_val),
    .dec      (cnt_dec),
    .zero     (cnt_zero)
  );

  always_ff @(posedge S_SYSCLK) begin
    if (S_RESET) begin
      state <= ST_IDLE;
    end else begin
      state <= state_d;
    end
  end

  always_comb begin
    state_d       = state;
    remaining_d   = remaining;
    hold_d        = hold_q;
    rx_valid_d    = 1'b0;
    rx_data_d     = S_RX_DATA;
    busy_d        = S_BUSY;
    frame_done_d  = 1'b0;
    frame_abort_d = 1'b0;
    cs_n_d        = S_SPI_CS_N;
    char_go_d     = S_CHAR_GO;
    wchar_d       = S_WCHAR;
    cnt_load      = 1'b0;
    cnt_val       = '0;
    cnt_dec       = 1'b0;

    // Dropping enable kills the frame from any active state, including a character in flight.
    if ((state != ST_IDLE) && !S_ENABLE) begin
      state_d       = ST_IDLE;
      char_go_d     = 1'b0;
      cs_n_d        = '1;
      busy_d        = 1'b0;
      frame_abort_d = 1'b1;
    end else begin
      case (state)
        ST_IDLE: begin
          if (S_CMD_VALID && S_CMD_READY && S_ENABLE) begin
            remaining_d = S_CMD_NCHAR;
            hold_d      = S_CS_HOLD;
            cnt_load    = 1'b1;
            cnt_val     = dly_load(S_CS_SETUP);
            busy_d      = 1'b1;
            cs_n_d      = ~(NUM_CS'(1) << S_CMD_CS);
            state_d     = ST_SETUP;
          end
        end
        ST_SETUP: begin
          if (cnt_zero) begin
            state_d = ST_TXWAIT;
          end else begin
            cnt_dec = 1'b1;
          end
        end
        ST_TXWAIT: begin
          if (S_TX_VALID && S_TX_READY) begin
            wchar_d   = S_TX_DATA;
            char_go_d = 1'b1;
            state_d   = ST_RUN;
          end
        end
        ST_RUN: begin
          if (S_CHAR_DONE) begin
            char_go_d  = 1'b0;
            rx_data_d  = S_RCHAR;
            rx_valid_d = 1'b1;
            if (remaining == '0) begin
              cnt_load = 1'b1;
              cnt_val  = dly_load(hold_q);
              state_d  = ST_HOLD;
            end else begin
              remaining_d = remaining - NCHAR_W'(1);
`ifdef SPI_CHAR_GAP_EN
              if (S_CHAR_GAP != '0) begin
                cnt_load = 1'b1;
                cnt_val  = dly_load(S_CHAR_GAP);
                state_d  = ST_GAP;
              end else begin
                state_d = ST_TXWAIT;
              end
`else
              state_d = ST_TXWAIT;
`endif
            end
          end
        end
        ST_HOLD: begin
          if (cnt_zero) begin
            cs_n_d       = '1;
            busy_d       = 1'b0;
            frame_done_d = 1'b1;
            state_d      = ST_IDLE;
          end else begin
            cnt_dec = 1'b1;
          end
        end
`ifdef SPI_CHAR_GAP_EN
        ST_GAP: begin
          if (cnt_zero) begin
            state_d = ST_TXWAIT;
          end else begin
            cnt_dec = 1'b1;
          end
        end
`endif
        default: state_d = ST_IDLE;
      endcase
    end

    // Handshake readies follow the state being entered so they are valid as soon as it is.
    cmd_ready_d = S_ENABLE && (state_d == ST_IDLE);
    tx_ready_d  = (state_d == ST_TXWAIT);
  end

  always_ff @(posedge S_SYSCLK) begin
    if (S_RESET) begin
      remaining     <= '0;
      hold_q        <= '0;
      S_CMD_READY   <= 1'b0;
      S_TX_READY    <= 1'b0;
      S_RX_VALID    <= 1'b0;
      S_RX_DATA     <= '0;
      S_BUSY        <= 1'b0;
      S_FRAME_DONE  <= 1'b0;
      S_FRAME_ABORT <= 1'b0;
      S_SPI_CS_N    <= '1;
      S_CHAR_GO     <= 1'b0;
      S_WCHAR       <= '0;
    end else begin
      remaining     <= remaining_d;
      hold_q        <= hold_d;
      S_CMD_READY   <= cmd_ready_d;
      S_TX_READY    <= tx_ready_d;
      S_RX_VALID    <= rx_valid_d;
      S_RX_DATA     <= rx_data_d;
      S_BUSY        <= busy_d;
      S_FRAME_DONE  <= frame_done_d;
      S_FRAME_ABORT <= frame_abort_d;
      S_SPI_CS_N    <= cs_n_d;
      S_CHAR_GO     <= char_go_d;
      S_WCHAR       <= wchar_d;
    end
  end

endmodule
